// File: rtl/mlp_infer_engine.sv
// mlp_infer_engine: two-layer fully connected inference engine with a single MAC, on-chip
// weight/bias/input memories, hidden-layer saturation and a sequential argmax stage.
//
// Optional feature: define MLP_HIDDEN_RELU_EN to apply ReLU after hidden saturation.
// Without it the hidden layer is linear (saturated value stored as is).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   start           run request, sampled only while idle
//   x_we/x_addr/x_wdata              input-sample memory write port
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata parameter memory write port (0=W12 1=B12 2=W23 3=B23)
//   busy            high while a run is in progress
//   done            one-cycle result-valid pulse
//   onehot_enc      one-hot winning class
//   class_idx       binary winning class
module mlp_infer_engine #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 20,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned X_W   = 2,
  parameter int unsigned W_W   = 16,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned ACC_W = 40
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               x_we,
  input  logic [$clog2(N_IN)-1:0]            x_addr,
  input  logic [X_W-1:0]                     x_wdata,
  input  logic                               cfg_we,
  input  logic [1:0]                         cfg_sel,
  input  logic [$clog2(N_IN*N_HID)-1:0]      cfg_addr,
  input  logic [W_W-1:0]                     cfg_wdata,
  output logic                               busy,
  output logic                               done,
  output logic [N_OUT-1:0]                   onehot_enc,
  output logic [$clog2(N_OUT)-1:0]           class_idx
);

  localparam int unsigned XAW    = $clog2(N_IN);
  localparam int unsigned CAW    = $clog2(N_IN * N_HID);
  localparam int unsigned HAW    = $clog2(N_HID);
  localparam int unsigned OAW    = $clog2(N_OUT);
  localparam int unsigned W23_AW = $clog2(N_OUT * N_HID);
  localparam int unsigned PMAX   = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned PW     = $clog2(PMAX + 2);
  localparam int unsigned NMAX   = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int unsigned NW     = $clog2(NMAX) + 1;
  localparam int unsigned PRODW  = 2 * W_W;

  localparam logic signed [ACC_W-1:0] H_MAX = {{(ACC_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] H_MIN = {{(ACC_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StL1, StL2, StArgmax, StDone} state_e;

  // Memories: no reset, contents survive a reset.
  logic signed [X_W-1:0] x_mem   [N_IN];
  logic signed [W_W-1:0] w12_mem [N_IN*N_HID];
  logic signed [W_W-1:0] b12_mem [N_HID];
  logic signed [W_W-1:0] w23_mem [N_OUT*N_HID];
  logic signed [W_W-1:0] b23_mem [N_OUT];

  state_e                  state_q;
  logic [PW-1:0]           phase_q;
  logic [NW-1:0]           nidx_q;
  logic [CAW-1:0]          wptr_q;
  logic signed [W_W-1:0]   op_a_q;
  logic signed [W_W-1:0]   w_rd_q;
  logic signed [ACC_W-1:0] bias_rd_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [W_W-1:0]   h_q     [N_HID];
  logic signed [ACC_W-1:0] score_q [N_OUT];
  logic signed [ACC_W-1:0] best_q;
  logic [OAW-1:0]          best_idx_q;

  logic                    in_l1;
  logic [PW-1:0]           plen;
  logic                    last_nrn;
  logic signed [PRODW-1:0] prod_full;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_l1;
  logic signed [ACC_W-1:0] bias_l2;
  logic signed [W_W-1:0]   h_sat;
  logic signed [W_W-1:0]   h_wb;
  logic signed [ACC_W-1:0] cand;
  logic                    take_cand;
  logic [OAW-1:0]          win_idx;

  // Host writes are only accepted while no run is in progress.
  always_ff @(posedge clk) begin
    if (!busy) begin
      if (x_we && (int'(x_addr) < int'(N_IN))) begin
        x_mem[x_addr] <= x_wdata;
      end
      if (cfg_we) begin
        unique case (cfg_sel)
          2'd0: if (int'(cfg_addr) < int'(N_IN * N_HID)) w12_mem[cfg_addr] <= cfg_wdata;
          2'd1: if (int'(cfg_addr) < int'(N_HID)) b12_mem[cfg_addr[HAW-1:0]] <= cfg_wdata;
          2'd2: if (int'(cfg_addr) < int'(N_OUT * N_HID)) begin
            w23_mem[cfg_addr[W23_AW-1:0]] <= cfg_wdata;
          end
          2'd3: if (int'(cfg_addr) < int'(N_OUT)) b23_mem[cfg_addr[OAW-1:0]] <= cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  assign in_l1     = (state_q == StL1);
  assign plen      = in_l1 ? PW'(N_IN) : PW'(N_HID);
  assign last_nrn  = in_l1 ? (nidx_q == NW'(N_HID - 1)) : (nidx_q == NW'(N_OUT - 1));
  assign prod_full = PRODW'(op_a_q) * PRODW'(w_rd_q);
  assign prod_ext  = ACC_W'(prod_full);
  assign bias_l1   = ACC_W'(b12_mem[nidx_q[HAW-1:0]]);
  // Layer-2 bias is realigned to Q.2FRAC to match the h*W products.
  assign bias_l2   = ACC_W'(b23_mem[nidx_q[OAW-1:0]]) <<< FRAC;

  always_comb begin
    if (acc_q > H_MAX) begin
      h_sat = H_MAX[W_W-1:0];
    end else if (acc_q < H_MIN) begin
      h_sat = H_MIN[W_W-1:0];
    end else begin
      h_sat = acc_q[W_W-1:0];
    end
`ifdef MLP_HIDDEN_RELU_EN
    h_wb = h_sat[W_W-1] ? '0 : h_sat;
`else
    h_wb = h_sat;
`endif
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    cand      = score_q[nidx_q[OAW-1:0]];
    take_cand = (nidx_q == '0) || (cand > best_q);
    win_idx   = take_cand ? nidx_q[OAW-1:0] : best_idx_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      nidx_q     <= '0;
      wptr_q     <= '0;
      op_a_q     <= '0;
      w_rd_q     <= '0;
      bias_rd_q  <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      onehot_enc <= '0;
      class_idx  <= '0;
      for (int k = 0; k < int'(N_HID); k++) h_q[k] <= '0;
      for (int k = 0; k < int'(N_OUT); k++) score_q[k] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StL1;
            busy    <= 1'b1;
            phase_q <= '0;
            nidx_q  <= '0;
            wptr_q  <= '0;
          end
        end
        StL1, StL2: begin
          // Per neuron: phase 0 fills the read pipeline, phases 1..plen multiply-accumulate,
          // phase plen+1 writes back.
          if (phase_q < plen) begin
            op_a_q <= in_l1 ? W_W'(x_mem[phase_q[XAW-1:0]]) : h_q[phase_q[HAW-1:0]];
            w_rd_q <= in_l1 ? w12_mem[wptr_q] : w23_mem[wptr_q[W23_AW-1:0]];
            wptr_q <= wptr_q + 1'b1;
          end
          if (phase_q == '0) begin
            bias_rd_q <= in_l1 ? bias_l1 : bias_l2;
          end
          if (phase_q == PW'(1)) begin
            acc_q <= bias_rd_q + prod_ext;
          end else if ((phase_q != '0) && (phase_q <= plen)) begin
            acc_q <= acc_q + prod_ext;
          end
          if (phase_q == plen + 1'b1) begin
            if (in_l1) begin
              h_q[nidx_q[HAW-1:0]] <= h_wb;
            end else begin
              score_q[nidx_q[OAW-1:0]] <= acc_q;
            end
            phase_q <= '0;
            if (last_nrn) begin
              nidx_q  <= '0;
              wptr_q  <= '0;
              state_q <= in_l1 ? StL2 : StArgmax;
            end else begin
              nidx_q <= nidx_q + 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StArgmax: begin
          if (take_cand) begin
            best_q <= cand;
          end
          best_idx_q <= win_idx;
          if (nidx_q == NW'(N_OUT - 1)) begin
            state_q    <= StDone;
            nidx_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            class_idx  <= win_idx;
            onehot_enc <= {{(N_OUT-1){1'b0}}, 1'b1} << win_idx;
          end else begin
            nidx_q <= nidx_q + 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_infer_engine.sv
// Self-checking bench for mlp_infer_engine at N_IN=4, N_HID=2, N_OUT=3 (latency 28).
module tb_mlp_infer_engine;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_HID = 2;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned X_W   = 2;
  localparam int unsigned W_W   = 16;
  localparam int unsigned FRAC  = 10;
  localparam int unsigned ACC_W = 40;
  localparam int L = N_HID * (N_IN + 2) + N_OUT * (N_HID + 2) + N_OUT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        x_we;
  logic [1:0]  x_addr;
  logic [1:0]  x_wdata;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        busy;
  logic        done;
  logic [2:0]  onehot_enc;
  logic [1:0]  class_idx;

  int checks   = 0;
  int failures = 0;

  // Host-side image of what has been loaded into the engine.
  int x_m   [N_IN];
  int w12_m [N_IN*N_HID];
  int b12_m [N_HID];
  int w23_m [N_OUT*N_HID];
  int b23_m [N_OUT];

  always #5 clk = ~clk;

  mlp_infer_engine #(
    .N_IN (N_IN),
    .N_HID(N_HID),
    .N_OUT(N_OUT),
    .X_W  (X_W),
    .W_W  (W_W),
    .FRAC (FRAC),
    .ACC_W(ACC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_we      (x_we),
    .x_addr    (x_addr),
    .x_wdata   (x_wdata),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .done      (done),
    .onehot_enc(onehot_enc),
    .class_idx (class_idx)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  // Reference: plain fixed-point arithmetic of the two layers plus argmax.
  function automatic int ref_class();
    longint acc;
    longint h [N_HID];
    longint s [N_OUT];
    int best;
    for (int j = 0; j < int'(N_HID); j++) begin
      acc = b12_m[j];
      for (int i = 0; i < int'(N_IN); i++) acc += longint'(x_m[i]) * w12_m[j*N_IN+i];
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`ifdef MLP_HIDDEN_RELU_EN
      if (acc < 0) acc = 0;
`endif
      h[j] = acc;
    end
    for (int k = 0; k < int'(N_OUT); k++) begin
      acc = longint'(b23_m[k]) * (longint'(1) << FRAC);
      for (int j = 0; j < int'(N_HID); j++) acc += h[j] * w23_m[k*N_HID+j];
      s[k] = acc;
    end
    best = 0;
    for (int k = 1; k < int'(N_OUT); k++) if (s[k] > s[best]) best = k;
    return best;
  endfunction

  task automatic put_x(input int i, input int v);
    @(negedge clk);
    x_we = 1'b1; x_addr = i[1:0]; x_wdata = v[1:0];
    @(negedge clk);
    x_we = 1'b0;
  endtask

  task automatic put_cfg(input int sel, input int a, input int v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel[1:0]; cfg_addr = a[2:0]; cfg_wdata = v[15:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic push_all();
    for (int i = 0; i < int'(N_IN); i++) put_x(i, x_m[i]);
    for (int a = 0; a < int'(N_IN*N_HID); a++) put_cfg(0, a, w12_m[a]);
    for (int a = 0; a < int'(N_HID); a++) put_cfg(1, a, b12_m[a]);
    for (int a = 0; a < int'(N_OUT*N_HID); a++) put_cfg(2, a, w23_m[a]);
    for (int a = 0; a < int'(N_OUT); a++) put_cfg(3, a, b23_m[a]);
  endtask

  // disturb: mid-run W23 write and second start, both of which must be ignored.
  task automatic run_check(input string tag, input bit disturb);
    int n;
    int exp_idx;
    int extra;
    bit busy_ok;
    logic [2:0] exp_oh;
    exp_idx = ref_class();
    exp_oh  = 3'b001 << exp_idx;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < L + 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (disturb && n == 6) begin
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd2; cfg_addr = 3'd2; cfg_wdata = 16'hFC00;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, L);
    check({tag, "_busy_run"}, busy_ok, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_class"}, class_idx, exp_idx);
    check({tag, "_onehot"}, onehot_enc, exp_oh);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_class_hold"}, class_idx, exp_idx);
  endtask

  task automatic scen1();
    for (int i = 0; i < int'(N_IN); i++) x_m[i] = 1;
    for (int a = 0; a < int'(N_IN*N_HID); a++) w12_m[a] = 'h0400;
    for (int a = 0; a < int'(N_HID); a++) b12_m[a] = 0;
    w23_m = '{'h0400, 'h0400, 'h0800, 'h0800, 0, 0};
    b23_m = '{0, 0, 0};
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_onehot", onehot_enc, 3'b000);
    check("rst_class", class_idx, 2'd0);
    reset = 1'b1;

    // Basic classification.
    scen1();
    push_all();
    run_check("s1", 1'b0);

    // Ignored writes and start during a run, then a clean rerun.
    run_check("s5", 1'b1);
    run_check("s5_rerun", 1'b0);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    check("s6_busy_before", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("s6_busy", busy, 1'b0);
    check("s6_done", done, 1'b0);
    check("s6_onehot", onehot_enc, 3'b000);
    check("s6_class", class_idx, 2'd0);
    reset = 1'b1;
    run_check("s6_fresh", 1'b0);

    // Tie across all classes.
    w23_m = '{0, 0, 0, 0, 0, 0};
    b23_m = '{'h0400, 'h0400, 'h0400};
    push_all();
    run_check("s2_tie", 1'b0);

    // Negative hidden values: ReLU-dependent winner.
    for (int a = 0; a < int'(N_IN*N_HID); a++) w12_m[a] = sx16('hFC00);
    b12_m = '{0, 0};
    w23_m = '{sx16('hFC00), sx16('hFC00), 0, 0, 0, 0};
    b23_m = '{0, 0, 'h0400};
    push_all();
    run_check("s3_relu", 1'b0);

    // Hidden saturation.
    w12_m = '{'h7FFF, 'h7FFF, 'h7FFF, 'h7FFF, 0, 0, 0, 0};
    b12_m = '{'h7FFF, 0};
    w23_m = '{'h0400, 'h0400, 0, 0, 0, 0};
    b23_m = '{0, 'h7FFF, 0};
    push_all();
    run_check("s4_sat", 1'b0);

    // Randomized parameter sets.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < int'(N_IN); i++) x_m[i] = int'($urandom_range(0, 3)) - 2;
      for (int a = 0; a < int'(N_IN*N_HID); a++) begin
        w12_m[a] = (r % 2 == 0) ? sx16(int'($urandom_range(0, 65535)))
                                : int'($urandom_range(0, 4095)) - 2048;
      end
      for (int a = 0; a < int'(N_HID); a++) b12_m[a] = sx16(int'($urandom_range(0, 65535)));
      for (int a = 0; a < int'(N_OUT*N_HID); a++) w23_m[a] = int'($urandom_range(0, 4095)) - 2048;
      for (int a = 0; a < int'(N_OUT); a++) b23_m[a] = int'($urandom_range(0, 4095)) - 2048;
      push_all();
      run_check($sformatf("rnd%0d", r), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
